// File: rtl/alu_issue_stage.sv
// EX-stage issue register for a 5-stage MIPS-style pipeline. It handles load-use stall
// detection, flush/stall bubble insertion, and EX/MEM and MEM/WB operand forwarding.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_ALUSrc1,
  input  logic             id_ALUSrc2,
  input  logic             id_Sign,
  input  logic [5:0]       id_ALUFun,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_shamt,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm32,
  input  logic             flush,
  input  logic             mem_RegWrite,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_result,
  input  logic             wb_RegWrite,
  input  logic [4:0]       wb_rd,
  input  logic [31:0]      wb_result,
  output logic             stall,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [5:0]       ALUFun,
  output logic             Sign,
  output logic [31:0]      ex_store_data,
  output logic [4:0]       ex_rd,
  output logic             ex_valid,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        src1;
    logic        src2;
    logic        sign;
    logic [5:0]  fun;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm32;
  } ex_reg_t;

  ex_reg_t     ex_q;
  ex_reg_t     id_pkt;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  assign id_pkt = '{valid:     id_valid,
                    reg_write: id_RegWrite,
                    mem_read:  id_MemRead,
                    src1:      id_ALUSrc1,
                    src2:      id_ALUSrc2,
                    sign:      id_Sign,
                    fun:       id_ALUFun,
                    rs:        id_rs,
                    rt:        id_rt,
                    rd:        id_rd,
                    shamt:     id_shamt,
                    rs_data:   id_rs_data,
                    rt_data:   id_rt_data,
                    imm32:     id_imm32};

  // A load in EX whose destination feeds the instruction in ID cannot forward in time.
  assign stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
                 ((ex_q.rd == id_rs) || (ex_q.rd == id_rt));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q      <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush || stall) ex_q <= '0;
      else                ex_q <= id_pkt;
      if (stall && !flush && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // NOTE: each always_comb output gets a default first so that no path can infer a latch.
  always_comb begin
    rs_fwd = ex_q.rs_data;
    if (mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == ex_q.rs))
      rs_fwd = mem_result;
    else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == ex_q.rs))
      rs_fwd = wb_result;
  end

  always_comb begin
    rt_fwd = ex_q.rt_data;
    if (mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == ex_q.rt))
      rt_fwd = mem_result;
    else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == ex_q.rt))
      rt_fwd = wb_result;
  end

  assign A             = ex_q.src1 ? {27'd0, ex_q.shamt} : rs_fwd;
  assign B             = ex_q.src2 ? ex_q.imm32 : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign ALUFun        = ex_q.fun;
  assign Sign          = ex_q.sign;
  assign ex_rd         = ex_q.rd;
  assign ex_valid      = ex_q.valid;
  assign ex_RegWrite   = ex_q.reg_write;
  assign ex_MemRead    = ex_q.mem_read;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage. It runs directed and random instruction streams
// against a model of pipeline contents that tracks which instruction sits in EX.
module tb_alu_issue_stage;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        src1;
    logic        src2;
    logic        sign;
    logic [5:0]  fun;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic mem_RegWrite, wb_RegWrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic stall, Sign, ex_valid, ex_RegWrite, ex_MemRead;
  logic [31:0] A, B, ex_store_data;
  logic [5:0]  ALUFun;
  logic [4:0]  ex_rd;
  logic [CNT_W-1:0] stall_cnt;

  instr_t id;
  instr_t ex_m;
  int unsigned cnt_m;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id.valid), .id_RegWrite(id.regwrite), .id_MemRead(id.memread),
    .id_ALUSrc1(id.src1), .id_ALUSrc2(id.src2), .id_Sign(id.sign),
    .id_ALUFun(id.fun), .id_rs(id.rs), .id_rt(id.rt), .id_rd(id.rd),
    .id_shamt(id.shamt), .id_rs_data(id.rs_data), .id_rt_data(id.rt_data),
    .id_imm32(id.imm), .flush(flush),
    .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall(stall), .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .stall_cnt(stall_cnt)
  );

  // Value a register read sees in EX: the youngest in-flight producer wins, r0 is always its own.
  function automatic logic [31:0] fwd_model(input logic [4:0] r, input logic [31:0] own);
    if (r == 5'd0) return own;
    if (mem_RegWrite && mem_rd == r) return mem_result;
    if (wb_RegWrite && wb_rd == r) return wb_result;
    return own;
  endfunction

  // True when a load occupying EX produces a register the ID instruction reads.
  function automatic logic hazard_model();
    if (!(ex_m.valid && ex_m.memread) || ex_m.rd == 5'd0 || !id.valid) return 1'b0;
    return (id.rs == ex_m.rd) || (id.rt == ex_m.rd);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] rs_v, rt_v;
    rs_v = fwd_model(ex_m.rs, ex_m.rs_data);
    rt_v = fwd_model(ex_m.rt, ex_m.rt_data);
    chk("stall",       32'(stall),       32'(hazard_model()));
    chk("A",           A,                ex_m.src1 ? 32'(ex_m.shamt) : rs_v);
    chk("B",           B,                ex_m.src2 ? ex_m.imm : rt_v);
    chk("store_data",  ex_store_data,    rt_v);
    chk("ALUFun",      32'(ALUFun),      32'(ex_m.fun));
    chk("Sign",        32'(Sign),        32'(ex_m.sign));
    chk("ex_rd",       32'(ex_rd),       32'(ex_m.rd));
    chk("ex_valid",    32'(ex_valid),    32'(ex_m.valid));
    chk("ex_RegWrite", 32'(ex_RegWrite), 32'(ex_m.regwrite));
    chk("ex_MemRead",  32'(ex_MemRead),  32'(ex_m.memread));
    chk("stall_cnt",   32'(stall_cnt),   cnt_m);
  endtask

  // Advance one clock: predict what EX will hold, clock, then compare everything.
  task automatic step(input logic f, output logic held);
    logic hz;
    flush = f;
    hz = hazard_model();
    held = hz && !f;
    if (f || hz) ex_m = '0;
    else         ex_m = id;
    if (held && cnt_m < CNT_MAX) cnt_m++;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check_all();
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.valid    = ($urandom_range(0, 7) != 0);
    r.regwrite = 1'($urandom);
    r.memread  = ($urandom_range(0, 2) == 0);
    r.src1     = ($urandom_range(0, 4) == 0);
    r.src2     = ($urandom_range(0, 3) == 0);
    r.sign     = 1'($urandom);
    r.fun      = 6'($urandom);
    r.rs       = 5'($urandom_range(0, 7));
    r.rt       = 5'($urandom_range(0, 7));
    r.rd       = 5'($urandom_range(0, 7));
    r.shamt    = 5'($urandom);
    r.rs_data  = $urandom;
    r.rt_data  = $urandom;
    r.imm      = $urandom;
    return r;
  endfunction

  function automatic instr_t alu_op(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [31:0] rs_d,
                                    input logic [31:0] rt_d);
    instr_t r = '0;
    r.valid = 1'b1; r.regwrite = 1'b1;
    r.rs = rs; r.rt = rt; r.rd = rd; r.rs_data = rs_d; r.rt_data = rt_d;
    return r;
  endfunction

  task automatic no_fwd();
    mem_RegWrite = 1'b0; wb_RegWrite = 1'b0;
    mem_rd = 5'd0; wb_rd = 5'd0; mem_result = '0; wb_result = '0;
  endtask

  initial begin
    logic held;
    logic [CNT_W-1:0] cnt_save;
    instr_t lw, add_dep;

    id = '0; flush = 1'b0; no_fwd();
    ex_m = '0; cnt_m = 0;
    lw = alu_op(5'd2, 5'd0, 5'd8, 32'h100, 32'h0);
    lw.memread = 1'b1;
    add_dep = alu_op(5'd8, 5'd9, 5'd10, 32'h1, 32'h2);

    // Power-on reset
    reset = 1'b0;
    #1;
    check_all();
    chk("rst_A", A, 32'h0);
    #20 reset = 1'b1;

    // Plain capture
    id = alu_op(5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
    step(1'b0, held);
    chk("plain_A", A, 32'h11);
    chk("plain_B", B, 32'h22);
    chk("plain_valid", 32'(ex_valid), 32'h1);

    // Double forward on rs=5, then MEM/WB only, then r0 never forwarded
    id = alu_op(5'd5, 5'd6, 5'd7, 32'h1234, 32'h5678);
    step(1'b0, held);
    mem_RegWrite = 1'b1; mem_rd = 5'd5; mem_result = 32'hAAAA;
    wb_RegWrite  = 1'b1; wb_rd  = 5'd5; wb_result  = 32'hBBBB;
    #1;
    chk("fwd_mem_A", A, 32'hAAAA);
    check_all();
    mem_RegWrite = 1'b0;
    #1;
    chk("fwd_wb_A", A, 32'hBBBB);
    id = alu_op(5'd0, 5'd0, 5'd7, 32'h77, 32'h88);
    mem_RegWrite = 1'b1; mem_rd = 5'd0; wb_RegWrite = 1'b1; wb_rd = 5'd0;
    step(1'b0, held);
    chk("r0_A", A, 32'h77);
    chk("r0_B", B, 32'h88);
    no_fwd();

    // Load-use: one bubble, counter 0->1, dependent op captured next edge
    id = lw;
    step(1'b0, held);
    id = add_dep;
    #1;
    chk("lu_stall", 32'(stall), 32'h1);
    step(1'b0, held);
    chk("lu_bubble", 32'(ex_valid), 32'h0);
    chk("lu_cnt", 32'(stall_cnt), 32'h1);
    step(1'b0, held);
    chk("lu_capture_rd", 32'(ex_rd), 32'd10);

    // Flush together with stall: bubble, counter unchanged
    id = lw;
    step(1'b0, held);
    id = add_dep;
    cnt_save = stall_cnt;
    step(1'b1, held);
    chk("fs_valid", 32'(ex_valid), 32'h0);
    chk("fs_cnt", 32'(stall_cnt), 32'(cnt_save));

    // Shift amount / immediate operands; store data still gets forwarded rt
    id = alu_op(5'd4, 5'd3, 5'd6, 32'h9999, 32'h5555);
    id.src1 = 1'b1; id.shamt = 5'd31; id.src2 = 1'b1; id.imm = 32'hFFFF8000;
    step(1'b0, held);
    mem_RegWrite = 1'b1; mem_rd = 5'd3; mem_result = 32'hCAFE;
    #1;
    chk("shamt_A", A, 32'h0000001F);
    chk("imm_B", B, 32'hFFFF8000);
    chk("imm_store", ex_store_data, 32'hCAFE);
    no_fwd();

    // Random stream; a held instruction is re-presented as upstream would
    held = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!held) id = rand_instr();
      mem_RegWrite = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_RegWrite  = 1'($urandom); wb_rd  = 5'($urandom_range(0, 7)); wb_result  = $urandom;
      step(($urandom_range(0, 9) == 0), held);
    end
    no_fwd();

    // Saturation: back-to-back self-dependent loads stall every other cycle
    id = lw;
    id.rs = 5'd8;
    for (int i = 0; i < 2 * CNT_MAX + 20; i++) step(1'b0, held);
    chk("sat_cnt", 32'(stall_cnt), CNT_MAX);

    // Reset mid-stall discards the stalled load; first capture on the next edge
    id = lw;
    step(1'b0, held);
    id = add_dep;
    #1;
    chk("pre_rst_stall", 32'(stall), 32'h1);
    #2 reset = 1'b0;
    ex_m = '0; cnt_m = 0;
    #1;
    check_all();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    #3 reset = 1'b1;
    step(1'b0, held);
    chk("post_rst_valid", 32'(ex_valid), 32'h1);
    chk("post_rst_rd", 32'(ex_rd), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: CNT_W, default 16, width of the load-use stall counter.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 id_valid, id_RegWrite, id_MemRead, id_ALUSrc1, id_ALUSrc2, id_Sign  in  1 each  decoded-stage controls; ALUSrc1=1 selects shamt for A; ALUSrc2=1 selects immediate for B.
REQ-005 id_ALUFun  in  6  ALU operation code; id_rs, id_rt, id_rd  in  5 each  register numbers; id_shamt  in  5  shift amount.
REQ-006 id_rs_data, id_rt_data, id_imm32  in  32 each  register-file read data and extended immediate.
REQ-007 flush  in  1  squash the instruction entering EX (branch/jump redirect).
REQ-008 mem_RegWrite  in  1, mem_rd  in  5, mem_result  in  32  EX/MEM forwarding source; wb_RegWrite  in  1, wb_rd  in  5, wb_result  in  32  MEM/WB forwarding source.
REQ-009 stall  out  1  combinational load-use hazard; upstream holds PC and IF/ID while high.
REQ-010 A, B  out  32 each  ALU operands; ALUFun  out  6; Sign  out  1.
REQ-011 ex_store_data  out  32  forwarded rt value; ex_rd  out  5; ex_valid, ex_RegWrite, ex_MemRead  out  1 each.
REQ-012 stall_cnt  out  CNT_W  number of load-use bubbles inserted.

Function
REQ-013 EX register set (valid, RegWrite, MemRead, ALUSrc1/2, Sign, ALUFun, rs, rt, rd, shamt, rs_data, rt_data, imm32) SHALL update on every rising clk edge; no enable.
REQ-014 stall SHALL be 1 iff ex_valid & ex_MemRead & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt); otherwise 0.
REQ-015 Priority per edge: flush, then stall, then capture.
REQ-016 flush=1: next-cycle bubble (valid, RegWrite, MemRead, ALUSrc1/2, Sign = 0, ALUFun = 0, rs/rt/rd = 0, data fields = 0), whether or not stall is high.
REQ-017 stall=1 and flush=0: next cycle holds the same bubble; ID inputs not captured (upstream re-presents them).
REQ-018 Otherwise: all id_* fields captured unchanged.
REQ-019 Load-use stall SHALL last exactly one cycle, since the bubble clears ex_MemRead.
REQ-020 Forwarded rs: mem_result if mem_RegWrite & mem_rd!=0 & mem_rd==ex_rs; else wb_result if wb_RegWrite & wb_rd!=0 & wb_rd==ex_rs; else registered rs_data.
REQ-021 Forwarded rt: same rule using ex_rt; EX/MEM always wins over MEM/WB.
REQ-022 Register 0 SHALL never be forwarded.
REQ-023 A = ALUSrc1 ? {27'b0, shamt} : forwarded rs; B = ALUSrc2 ? imm32 : forwarded rt.
REQ-024 ex_store_data SHALL be forwarded rt, independent of ALUSrc2.
REQ-025 Forwarding and operand muxes SHALL be combinational from the EX registers; ALU inputs are valid the cycle after capture, zero additional latency.
REQ-026 ALUFun and Sign outputs SHALL be the registered values.
REQ-027 stall_cnt SHALL increment on each edge where stall=1 and flush=0.
REQ-028 stall_cnt SHALL saturate at all-ones, never wrap.

Reset
REQ-029 reset low SHALL asynchronously clear all EX registers and stall_cnt to 0, giving ex_valid=0, ALUFun=0, Sign=0, A=0, B=0, ex_store_data=0, ex_rd=0, stall=0.
REQ-030 Reset asserted mid-stall SHALL discard the stalled instruction.
REQ-031 The first capture SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-032 Plain capture: id_rs_data=0x11, id_rt_data=0x22, ALUSrc1/2=0, ALUFun=0x00, no forwarding -> next cycle A=0x11, B=0x22, ALUFun=0x00, ex_valid=1.
REQ-033 Double forward: ex_rs=5, mem_rd=5, wb_rd=5, both RegWrite=1, mem_result=0xAAAA, wb_result=0xBBBB -> A=0xAAAA; with mem_RegWrite=0 -> A=0xBBBB; with rs=0 -> A=registered rs_data.
REQ-034 Load-use: EX holds lw rd=8; ID presents add with rs=8 -> stall=1 for one cycle, EX bubble (ex_valid=0), stall_cnt 0->1; add captured the following edge.
REQ-035 flush and stall together -> bubble inserted, stall_cnt unchanged.
REQ-036 Shift/immediate: ALUSrc1=1, shamt=31, ALUSrc2=1, imm32=0xFFFF8000 -> A=0x0000001F, B=0xFFFF8000, ex_store_data = forwarded rt.
REQ-037 Saturation and reset: preload stall_cnt to all-ones via repeated hazards, one more hazard -> stays 0xFFFF; reset pulse low mid-cycle -> all outputs 0 immediately.
